// File: rtl/seven_segments_decoder.sv
// rtl/seven_segments_decoder.sv - two-digit seven-segment pattern to hex byte decoder
module seven_segments_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] y,
  output logic [7:0]  x,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cap_q, cap_d;
  logic [7:0]  x_q, x_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [6:0]  seg_sel;
  logic [3:0]  nib;
  logic        bad;

  // dp bits are captured with the word but never decoded
  logic        unused_dp;
  assign unused_dp = cap_q[15] ^ cap_q[7];

  // single shared glyph lookup, fed from the high digit in HIGH and the low digit otherwise
  always_comb begin
    seg_sel = (state_q == HIGH) ? cap_q[14:8] : cap_q[6:0];
    nib     = 4'h0;
    bad     = 1'b0;
    case (seg_sel)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: begin
        nib = 4'h0;
        bad = 1'b1;
      end
    endcase
  end

  // next-state and datapath updates; IDLE and DONE share the capture path
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    x_d     = x_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cap_d   = y;
          x_d     = 8'h00;
          err_d   = 1'b0;
          done_d  = 1'b0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        x_d[7:4] = nib;
        err_d    = err_q | bad;
        state_d  = LOW;
      end
      LOW: begin
        x_d[3:0] = nib;
        err_d    = err_q | bad;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and result registers; reset discards any partial decode
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= 16'h0000;
      x_q     <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      x_q     <= x_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign x     = x_q;
  assign done  = done_q;
  assign error = err_q;

endmodule

// File: tb/tb_seven_segments_decoder.sv
// tb/tb_seven_segments_decoder.sv - self-checking bench for seven_segments_decoder
module tb_seven_segments_decoder;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] y;
  logic [7:0]  x;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  seven_segments_decoder dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .y     (y),
    .x     (x),
    .done  (done),
    .error (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // glyph table indexed by hex value
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // returns {illegal, value}
  function automatic logic [4:0] model_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) return {1'b0, 4'(i)};
    end
    return 5'h10;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference model: whole result computed at capture, revealed one digit per cycle
  int         m_phase = 0;
  logic [4:0] m_hi, m_lo;
  logic [7:0] m_x;
  logic       m_done, m_err;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      m_x     = 8'h00;
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_hi    = model_dec(y[14:8]);
        m_lo    = model_dec(y[6:0]);
        m_x     = 8'h00;
        m_err   = 1'b0;
        m_done  = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_x     = {m_hi[3:0], 4'h0};
      m_err   = m_hi[4];
      m_phase = 2;
    end else begin
      m_x     = {m_hi[3:0], m_lo[3:0]};
      m_err   = m_hi[4] | m_lo[4];
      m_done  = 1'b1;
      m_phase = 0;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_x", x, m_x);
      check("model_done", done, m_done);
      check("model_error", error, m_err);
    end
  end

  task automatic txn(input logic [15:0] yv, input logic [7:0] ex, input logic ee, input string nm);
    int lat;
    @(negedge clock);
    y     = yv;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    y     = 16'($urandom);
    lat   = 1;
    check({nm, "_done_drop"}, done, 1'b0);
    while (!done && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_x"}, x, ex);
    check({nm, "_error"}, error, ee);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    y     = 16'h0000;
    @(negedge clock);
    @(negedge clock);
    chk_en = 1;
    check("reset_x", x, 8'h00);
    check("reset_done", done, 1'b0);
    check("reset_error", error, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_x", x, 8'h00);
    check("idle_done", done, 1'b0);

    txn(16'h063F, 8'h10, 1'b0, "t10");
    repeat (4) @(negedge clock);
    check("hold_x", x, 8'h10);
    check("hold_done", done, 1'b1);

    txn(16'h7771, 8'hAF, 1'b0, "tAF");
    txn(16'h6D7D, 8'h56, 1'b0, "t56");
    txn(16'h0000, 8'h00, 1'b1, "t00_bad");
    txn(16'h86BF, 8'h10, 1'b0, "tdp");
    txn(16'h7F80, 8'h80, 1'b1, "tlo_bad");

    // reset while the low digit is being decoded
    @(negedge clock);
    y     = 16'h4F66;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_x", x, 8'h00);
    check("midrst_done", done, 1'b0);
    check("midrst_error", error, 1'b0);
    txn(16'h4F66, 8'h34, 1'b0, "t34");

    // start during HIGH with a different word must be ignored
    @(negedge clock);
    y     = 16'h063F;
    start = 1'b1;
    @(negedge clock);
    y     = 16'h7771;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("ignore_x", x, 8'h10);
    check("ignore_done", done, 1'b1);

    // reset and start together: nothing captured
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    y     = 16'h5B4F;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_start_x", x, 8'h00);
    check("rst_start_done", done, 1'b0);

    // start held high: one done cycle per transaction
    @(negedge clock);
    y     = 16'h5B4F;
    start = 1'b1;
    repeat (9) @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("held_x", x, 8'h23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_segments_decoder.md
# seven_segments_decoder

Inverse of the seven-segment encoder. Accepts a 16-bit word holding two seven-segment digit patterns and recovers the 8-bit hexadecimal value they display. It also flags any pattern that is not a legal hex glyph. It sits on the loopback/self-check path behind the display encoder and uses the same start/done handshake, so encoder output can be fed straight back and compared.

## Interface
- No parameters; widths are fixed.
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; takes priority over every other input.
- start  input  1  request; sampled only in IDLE or DONE.
- y  input  16  segment word. y[15:8] is the high digit, y[7:0] the low digit. Each byte is {dp,g,f,e,d,c,b,a}, segments active-high.
- x  output  8  decoded value. x[7:4] comes from the high digit, x[3:0] from the low digit.
- done  output  1  high while the result on x/error is valid.
- error  output  1  high if either digit pattern was illegal; valid with done.

## Operation
- Legal glyphs, bits g..a (dp bit ignored):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Any other 7-bit pattern decodes to nibble 0 and sets error. Once set, error is sticky until the next capture.
- FSM states: IDLE, HIGH, LOW, DONE.
  - IDLE: if start, capture y into an internal 16-bit register, clear x and error, clear done, go to HIGH. Otherwise stay.
  - HIGH: x[7:4] <= decode(captured[14:8]); error |= invalid; go to LOW. start is ignored.
  - LOW: x[3:0] <= decode(captured[6:0]); error |= invalid; done <= 1; go to DONE. start is ignored.
  - DONE: hold x, error and done. If start, behave exactly as IDLE-with-start (capture, clear outputs, go to HIGH). Otherwise stay.
- Only one decode lookup exists; it is shared between HIGH and LOW through a mux on the captured register.
- y may change freely after the capture edge; only the captured copy is decoded.

## Timing
- Reset values: state=IDLE, x=8'h00, done=0, error=0, capture register=16'h0000.
- Capture edge is E0 (start=1 sampled in IDLE or DONE).
  - E0+1: x[7:4] valid.
  - E0+2: x[3:0] valid, done=1, error final.
  - done is therefore seen 3 rising edges after start is first asserted, counting the capture edge.
- done is a level, not a pulse. It stays high until the capture edge of the next accepted start, then drops in the same edge.
- start held high continuously: a new capture happens on every entry to DONE. done is high for exactly one cycle per transaction.
- start asserted in HIGH/LOW: ignored, with no queuing.
- Reset asserted in any state, including HIGH/LOW mid-decode: at the next edge all outputs return to reset values and the partial result is discarded.
- Reset and start high in the same cycle: reset wins and nothing is captured.

## Test plan
- Reset with start=0 for 2 cycles: x=00, done=0, error=0. Hold start=0 for 10 cycles: outputs unchanged.
- y=16'h063F, start pulsed 1 cycle: done rises 3 edges later with x=8'h10, error=0. Values hold until the next start.
- Back-to-back transactions:
  - y=16'h7771: x=AF, error=0.
  - then y=16'h6D7D: x=56.
  - In both, done drops on the capture edge and y is changed one cycle after capture.
- Illegal and dp cases:
  - y=16'h0000: x=00, error=1.
  - then y=16'h86BF (dp bits set): x=10, error=0, proving error clears and dp is ignored.
- Reset mid-op: start with y=16'h4F66, assert reset during LOW. Next edge: x=00, done=0, state IDLE. A later start with the same y gives x=34.
- start re-asserted while in HIGH with a different y: ignored. Result matches the originally captured y.
